// File: rtl/wdgrv_timer_core.sv
// Two-stage watchdog timer core: warn on first timeout, bite on second.
// Counter, flags and state are all flops; outputs come straight from them.
module wdgrv_timer_core #(
   parameter int unsigned CNT_SHIFT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wden_i,
   input  logic [9:0]  wtocnt_i,
   input  logic        s1wto_clr_i,
   input  logic        s2wto_clr_i,
   input  logic        cnt_we_i,
   input  logic [31:0] cnt_wdata_i,
   output logic [31:0] wdcnt_o,
   output logic        s1wto_o,
   output logic        s2wto_o,
   output logic        irq_o,
   output logic        rst_req_o
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      WARNED,
      BITTEN
   } state_t;

   state_t      r_state;
   logic [31:0] r_cnt;
   logic        r_s1wto;
   logic        r_s2wto;

   logic [31:0] w_limit;
   logic        w_run;
   logic        w_to;

   assign w_limit = {22'd0, wtocnt_i} << CNT_SHIFT;
   assign w_run   = wden_i && (r_state == ARMED || r_state == WARNED);
   // A refresh on the timeout edge beats the bite.
   assign w_to    = w_run && (wtocnt_i != 10'd0) &&
                    (r_cnt == w_limit) && !cnt_we_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_s1wto <= 1'b0;
         r_s2wto <= 1'b0;
      end else begin
         if (cnt_we_i)
            r_cnt <= cnt_wdata_i;
         else if (w_to)
            r_cnt <= '0;
         else if (w_run && r_cnt != '1)
            r_cnt <= r_cnt + 32'd1;

         if (w_to && r_state == ARMED)
            r_s1wto <= 1'b1;
         else if (s1wto_clr_i)
            r_s1wto <= 1'b0;

         if (w_to && r_state == WARNED)
            r_s2wto <= 1'b1;
         else if (s2wto_clr_i)
            r_s2wto <= 1'b0;

         unique case (r_state)
            IDLE: begin
               if (wden_i && !r_s2wto)
                  r_state <= (r_s1wto && !s1wto_clr_i) ? WARNED : ARMED;
            end
            ARMED: begin
               if (!wden_i)
                  r_state <= IDLE;
               else if (w_to)
                  r_state <= WARNED;
            end
            WARNED: begin
               if (!wden_i)
                  r_state <= IDLE;
               else if (w_to)
                  r_state <= BITTEN;
               else if (s1wto_clr_i)
                  r_state <= ARMED;
            end
            BITTEN: begin
               if (s2wto_clr_i)
                  r_state <= wden_i ? ARMED : IDLE;
            end
         endcase
      end
   end

   assign wdcnt_o   = r_cnt;
   assign s1wto_o   = r_s1wto;
   assign s2wto_o   = r_s2wto;
   assign irq_o     = r_s1wto;
   assign rst_req_o = r_s2wto;

endmodule

// File: tb/tb_wdgrv_timer_core.sv
// Bench for wdgrv_timer_core: directed scenarios plus random traffic,
// all checked every cycle against a behavioural watchdog model.
module tb_wdgrv_timer_core;

   localparam int SH = 4;
   localparam longint MAXC = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        wden;
   logic [9:0]  wtocnt;
   logic        s1c;
   logic        s2c;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] wdcnt_o;
   logic        s1wto_o;
   logic        s2wto_o;
   logic        irq_o;
   logic        rst_req_o;

   int n_cmp = 0;
   int n_bad = 0;

   longint m_cnt;
   bit     m_s1, m_s2, m_live, m_warn, m_bit;

   wdgrv_timer_core #(.CNT_SHIFT(SH)) dut (
      .clk         (clk),
      .rst         (rst),
      .wden_i      (wden),
      .wtocnt_i    (wtocnt),
      .s1wto_clr_i (s1c),
      .s2wto_clr_i (s2c),
      .cnt_we_i    (we),
      .cnt_wdata_i (wdata),
      .wdcnt_o     (wdcnt_o),
      .s1wto_o     (s1wto_o),
      .s2wto_o     (s2wto_o),
      .irq_o       (irq_o),
      .rst_req_o   (rst_req_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      m_cnt  = 0;
      m_s1   = 0;
      m_s2   = 0;
      m_live = 0;
      m_warn = 0;
      m_bit  = 0;
   endfunction

   // Watchdog behaviour for one clock edge, from the pre-edge view.
   function automatic void model_edge();
      longint lim  = longint'(wtocnt) << SH;
      bit     run  = m_live && wden;
      bit     to   = run && wtocnt != 0 && m_cnt == lim && !we;
      bit     o_s1 = m_s1;
      bit     o_s2 = m_s2;
      if (we) m_cnt = longint'(wdata);
      else if (to) m_cnt = 0;
      else if (run && m_cnt < MAXC) m_cnt = m_cnt + 1;
      if (to && !m_warn) m_s1 = 1;
      else if (s1c) m_s1 = 0;
      if (to && m_warn) m_s2 = 1;
      else if (s2c) m_s2 = 0;
      if (m_bit) begin
         if (s2c) begin
            m_bit  = 0;
            m_live = wden;
            m_warn = 0;
         end
      end else if (!m_live) begin
         if (wden && !o_s2) begin
            m_live = 1;
            m_warn = o_s1 && !s1c;
         end
      end else if (!wden) begin
         m_live = 0;
      end else if (to) begin
         if (m_warn) begin
            m_bit  = 1;
            m_live = 0;
         end else begin
            m_warn = 1;
         end
      end else if (s1c) begin
         m_warn = 0;
      end
   endfunction

   task automatic cmp_model();
      chk("cnt", wdcnt_o, m_cnt[31:0]);
      chk("s1", 32'(s1wto_o), 32'(m_s1));
      chk("s2", 32'(s2wto_o), 32'(m_s2));
      chk("irq", 32'(irq_o), 32'(m_s1));
      chk("rreq", 32'(rst_req_o), 32'(m_s2));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_clear();
      else model_edge();
      #1;
      cmp_model();
   endtask

   task automatic idle_in();
      wden   = 0;
      wtocnt = 0;
      s1c    = 0;
      s2c    = 0;
      we     = 0;
      wdata  = 0;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1;
      tick();
      tick();
      chk("rst_cnt", wdcnt_o, 32'd0);
      chk("rst_flags", {29'd0, s1wto_o, s2wto_o, irq_o | rst_req_o}, 32'd0);
      rst = 0;
   endtask

   task automatic strobe_we(input logic [31:0] d);
      we    = 1;
      wdata = d;
      tick();
      we    = 0;
   endtask

   initial begin
      int n;
      bit saw;
      model_clear();
      idle_in();
      rst = 1;
      #1;
      chk("async_rst", {wdcnt_o[0], s1wto_o, s2wto_o}, 32'd0);
      @(negedge clk);
      do_reset();

      // Two-stage timeout latency from reset.
      wden   = 1;
      wtocnt = 2;
      n = 0;
      while (n < 200 && !s1wto_o) begin
         tick();
         n++;
      end
      chk("s1_lat", 32'(n), 32'd34);
      chk("s1_cnt0", wdcnt_o, 32'd0);
      chk("irq_up", 32'(irq_o), 32'd1);
      n = 0;
      while (n < 200 && !s2wto_o) begin
         tick();
         n++;
      end
      chk("s2_lat", 32'(n), 32'd33);
      chk("rreq_up", 32'(rst_req_o), 32'd1);

      // Periodic refresh keeps the dog quiet.
      do_reset();
      wden   = 1;
      wtocnt = 2;
      saw    = 0;
      for (int i = 1; i <= 1000; i++) begin
         if (i % 20 == 0) strobe_we(32'd0);
         else tick();
         saw |= s1wto_o;
      end
      chk("refresh_quiet", 32'(saw), 32'd0);

      // Refresh on the exact stage-2 timeout edge.
      do_reset();
      wden   = 1;
      wtocnt = 2;
      repeat (34) tick();
      repeat (32) tick();
      chk("pre_bite_cnt", wdcnt_o, 32'd32);
      strobe_we(32'd5);
      chk("bite_load", wdcnt_o, 32'd5);
      chk("bite_supp", 32'(s2wto_o), 32'd0);
      n = 0;
      while (n < 200 && !s2wto_o) begin
         tick();
         n++;
      end
      chk("still_warned", 32'(n), 32'd28);

      // Clear and set of S1WTO in the same cycle.
      do_reset();
      wden   = 1;
      wtocnt = 2;
      repeat (33) tick();
      s1c = 1;
      tick();
      s1c = 0;
      chk("set_wins", 32'(s1wto_o), 32'd1);

      // Enable dropped mid-count freezes the counter.
      do_reset();
      wden   = 1;
      wtocnt = 2;
      repeat (11) tick();
      chk("pre_freeze", wdcnt_o, 32'd10);
      wden = 0;
      repeat (10) tick();
      chk("frozen", wdcnt_o, 32'd10);
      wden = 1;
      tick();
      chk("resume0", wdcnt_o, 32'd10);
      tick();
      chk("resume1", wdcnt_o, 32'd11);

      // Saturation with timeouts disabled.
      do_reset();
      wden   = 1;
      wtocnt = 0;
      tick();
      strobe_we(32'hFFFF_FFF0);
      repeat (15) tick();
      chk("sat", wdcnt_o, 32'hFFFF_FFFF);
      repeat (5) tick();
      chk("sat_hold", wdcnt_o, 32'hFFFF_FFFF);
      chk("sat_noflag", {30'd0, s1wto_o, s2wto_o}, 32'd0);

      // Asynchronous reset while bitten, then re-arm.
      do_reset();
      wden   = 1;
      wtocnt = 1;
      repeat (35) tick();
      chk("bitten", 32'(s2wto_o), 32'd1);
      repeat (3) tick();
      #2;
      rst = 1;
      #1;
      chk("arst_cnt", wdcnt_o, 32'd0);
      chk("arst_out", {28'd0, s1wto_o, s2wto_o, irq_o, rst_req_o}, 32'd0);
      model_clear();
      tick();
      rst = 0;
      tick();
      chk("rearm0", wdcnt_o, 32'd0);
      tick();
      chk("rearm1", wdcnt_o, 32'd1);

      // Random traffic against the model.
      do_reset();
      wtocnt = 10'($urandom_range(1, 3));
      for (int i = 0; i < 3000; i++) begin
         wden = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 99) == 0)
            wtocnt = 10'($urandom_range(0, 3));
         we = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 199) == 0) wdata = $urandom;
         else wdata = 32'($urandom_range(0, 60));
         s1c = ($urandom_range(0, 24) == 0);
         s2c = ($urandom_range(0, 24) == 0);
         tick();
      end
      idle_in();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wdgrv_timer_core.md
WDGRV_TIMER_CORE -- requirements
Module: wdgrv_timer_core

Interface
REQ-001 SHALL have parameter CNT_SHIFT, default 4, left-shift applied to WTOCNT to form the timeout limit; legal range 0..22.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port wden_i, input, 1, WDCSR.WDEN, the watchdog enable.
REQ-005 SHALL have port wtocnt_i, input, 10, WDCSR.WTOCNT, the timeout count.
REQ-006 SHALL have port s1wto_clr_i, input, 1, one-cycle write-1-to-clear strobe for S1WTO.
REQ-007 SHALL have port s2wto_clr_i, input, 1, one-cycle write-1-to-clear strobe for S2WTO.
REQ-008 SHALL have port cnt_we_i, input, 1, one-cycle WDCNT write strobe (the refresh).
REQ-009 SHALL have port cnt_wdata_i, input, 32, WDCNT write data.
REQ-010 SHALL have port wdcnt_o, output, 32, the current counter value for WDCNT readback.
REQ-011 SHALL have port s1wto_o, output, 1, the stage-1 timeout flag for WDCSR.S1WTO.
REQ-012 SHALL have port s2wto_o, output, 1, the stage-2 timeout flag for WDCSR.S2WTO.
REQ-013 SHALL have port irq_o, output, 1, the interrupt level, equal to s1wto_o.
REQ-014 SHALL have port rst_req_o, output, 1, the system reset request level, equal to s2wto_o.

Function
REQ-015 SHALL form LIMIT as a 32-bit value: zero-extended wtocnt_i shifted left by CNT_SHIFT, with no truncation of wtocnt_i bits.
REQ-016 SHALL implement the states IDLE, ARMED, WARNED and BITTEN.
REQ-017 SHALL go from IDLE to ARMED on any edge with wden_i=1 and s2wto=0.
REQ-018 SHALL go from ARMED or WARNED to IDLE on any edge with wden_i=0; the counter and flags hold, and on re-enable the state resumes as ARMED if s1wto=0, else WARNED.
REQ-019 SHALL, in ARMED or WARNED, increment the counter by 1 per clk, saturating at 0xFFFFFFFF with no wrap.
REQ-020 SHALL declare a timeout on the edge where the state is ARMED or WARNED, wtocnt_i!=0 and the counter equals LIMIT, so the timeout period is LIMIT+1 enabled cycles.
REQ-021 SHALL, on a timeout in ARMED, reset the counter to 0, set s1wto and move to WARNED.
REQ-022 SHALL, on a timeout in WARNED, reset the counter to 0, set s2wto and move to BITTEN.
REQ-023 SHALL, when wtocnt_i=0, suppress all timeouts while the counter still counts and saturates.
REQ-024 SHALL hold the counter in BITTEN, and leave BITTEN only on s2wto_clr_i, going to ARMED if wden_i=1, else IDLE.
REQ-025 SHALL make cnt_we_i load cnt_wdata_i into the counter on the next edge in any state, taking priority over increment and the timeout zeroing; a load does not by itself change the state or the flags.
REQ-026 SHALL make s1wto_clr_i clear s1wto and move WARNED to ARMED.
REQ-027 SHALL make s2wto_clr_i clear s2wto.
REQ-028 SHALL, when a flag clear and a flag set occur in the same cycle, let the set win.
REQ-029 SHALL, when cnt_we_i coincides with a timeout edge, apply the load and suppress the timeout, because a refresh beats a bite.
REQ-030 SHALL, if the counter is loaded with a value greater than LIMIT, or LIMIT later drops below the counter, declare no timeout until the counter saturates or is reloaded; this is a documented software hazard.
REQ-031 SHALL register every output directly from flops with no combinational path from input to output.

Reset
REQ-032 SHALL, while rst=1, asynchronously force the state to IDLE, the counter to 0, and s1wto, s2wto, irq_o and rst_req_o all to 0.
REQ-033 SHALL, on rst deassertion, take its first transition on the next rising clk edge; a reset mid-count discards all progress.

Verification
REQ-034 SHALL cover: CNT_SHIFT=4, wtocnt=2, wden=1 from reset -> s1wto_o/irq_o rise after 33 enabled clks, wdcnt_o=0 the same cycle, and s2wto_o/rst_req_o rise 33 clks later.
REQ-035 SHALL cover: cnt_we_i with data 0 issued every 20 clks in ARMED (wtocnt=2) -> s1wto_o never rises over 1000 clks.
REQ-036 SHALL cover: cnt_we_i on the exact timeout edge in WARNED -> counter = cnt_wdata_i, s2wto_o stays 0, state stays WARNED.
REQ-037 SHALL cover: s1wto_clr_i and a stage-1 timeout in the same cycle -> s1wto_o=1; wden_i dropped for 10 clks mid-count -> wdcnt_o frozen, and counting resumes from the same value.
REQ-038 SHALL cover: wtocnt=0 with cnt_we_i loading 0xFFFFFFF0 -> counter saturates at 0xFFFFFFFF after 15 clks with no flag set.
REQ-039 SHALL cover: rst pulsed mid-count while BITTEN -> all outputs 0 immediately with no clock edge, and the block re-arms on the first edge after release.
